led_scan_capture: RTL and testbench

Receive-side counterpart of the 16x16 LED matrix scan driver. Samples the 36-bit row-scan word the driver places on GPIO_1 and rebuilds full 16x16 red and green frames. Publishes each completed frame with a one-cycle valid strobe. Sits beside the LED driver, looping GPIO_1 back for on-board self-check and simulation scoreboarding of the Game of Life display path.

---
 rtl/led_matrix_pkg.sv | 20 ++
 rtl/scan_word_filter.sv | 53 +++++
 rtl/led_scan_capture.sv | 158 +++++++++++++++
 tb/tb_led_scan_capture.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scan path: scan-word field layout,
// matrix geometry, frame type and the capture FSM state encoding.
package led_matrix_pkg;

  localparam int MATRIX_ROWS = 16;
  localparam int ROW_LSB     = 0;
  localparam int RED_LSB     = 4;
  localparam int GRN_LSB     = 20;
  localparam int FIELD_W     = 16;
  localparam int SCAN_W      = 36;

  typedef logic [15:0][15:0] frame16_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/scan_word_filter.sv
// Input register and stability filter for the 36-bit row-scan word.
// A word is accepted once it has been seen unchanged for STABLE_CYCLES
// sampled cycles; accept is a single-cycle strobe alongside the word.
module scan_word_filter
  import led_matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [SCAN_W-1:0] scan_in,
  output logic [SCAN_W-1:0] word,
  output logic              accept
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

  logic [SCAN_W-1:0] in_q;
  logic [SCAN_W-1:0] in_prev;
  logic [7:0]        stab_cnt;
  logic              same;

  assign same   = (in_q == in_prev);
  // Accept on the cycle the counter is about to reach its ceiling, so each
  // stable run yields exactly one strobe.
  assign accept = capture_en && same && (stab_cnt == CNT_PRE);
  assign word   = in_q;

  // Single input register plus a copy of its previous value for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= '0;
      in_prev <= '0;
    end else begin
      in_q    <= scan_in;
      in_prev <= in_q;
    end
  end

  // Stability counter: restarts on any change or while capture is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_cnt <= '0;
    end else if (!capture_en || !same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CNT_MAX) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/led_scan_capture.sv
// Rebuilds 16x16 red/green frames from the LED driver's row-scan word.
// Optional row-order checking is enabled by defining LED_CAPTURE_SEQ_CHECK_EN;
// without it seq_err is tied low and rows are accepted in any order.
module led_scan_capture
  import led_matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture_en,
  input  logic [35:0]         scan_in,
  output logic [15:0][15:0]   RedFrame,
  output logic [15:0][15:0]   GrnFrame,
  output logic                frame_valid,
  output logic [7:0]          dropped_frames,
  output logic                seq_err
);

  logic [SCAN_W-1:0]  acc_word;
  logic               accept;
  logic [3:0]         acc_row;
  logic [FIELD_W-1:0] acc_red;
  logic [FIELD_W-1:0] acc_grn;

  frame16_t   shadow_red;
  frame16_t   shadow_grn;
  logic [15:0] row_mask;
  logic [15:0] mask_with_row;
  cap_state_t state;
  cap_state_t next_state;
  logic       row15;
  logic       seq_bad;
  logic       commit_req;
  logic       drop_req;

  scan_word_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .capture_en(capture_en),
    .scan_in   (scan_in),
    .word      (acc_word),
    .accept    (accept)
  );

  assign acc_row = acc_word[ROW_LSB +: 4];
  assign acc_red = acc_word[RED_LSB +: FIELD_W];
  assign acc_grn = acc_word[GRN_LSB +: FIELD_W];

`ifdef LED_CAPTURE_SEQ_CHECK_EN
  logic [3:0] last_row;
  logic       have_last;

  // Track the most recent accepted row; history is forgotten while capture is off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_row  <= '0;
      have_last <= 1'b0;
    end else if (!capture_en) begin
      have_last <= 1'b0;
    end else if (accept) begin
      last_row  <= acc_row;
      have_last <= 1'b1;
    end
  end

  assign seq_bad = accept && have_last && (acc_row != last_row + 4'd1);

  // Sticky sequence error, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_err <= 1'b0;
    end else if (seq_bad) begin
      seq_err <= 1'b1;
    end
  end
`else
  assign seq_bad = 1'b0;
  assign seq_err = 1'b0;
`endif

  // Frame-completion decode for the word being accepted this cycle.
  always_comb begin
    mask_with_row = row_mask | (16'd1 << acc_row);
    row15         = accept && (acc_row == 4'd15);
    commit_req    = row15 && !seq_bad && (mask_with_row == 16'hFFFF);
    drop_req      = row15 && !seq_bad && (mask_with_row != 16'hFFFF);
  end

  // Next-state logic: COMMIT lasts one cycle; capture_en low forces IDLE.
  always_comb begin
    next_state = ST_FILL;
    case (state)
      ST_IDLE:   next_state = ST_FILL;
      ST_FILL:   next_state = commit_req ? ST_COMMIT : ST_FILL;
      ST_COMMIT: next_state = ST_FILL;
      default:   next_state = ST_IDLE;
    endcase
    if (!capture_en) next_state = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Row mask: set per accepted row, restarted at row 15 or on a sequence break.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_mask <= '0;
    end else if (!capture_en) begin
      row_mask <= '0;
    end else if (accept) begin
      if (seq_bad)    row_mask <= 16'd1 << acc_row;
      else if (row15) row_mask <= '0;
      else            row_mask <= mask_with_row;
    end
  end

  // Shadow buffers take the column fields of every accepted row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_red <= '0;
      shadow_grn <= '0;
    end else if (accept) begin
      shadow_red[acc_row] <= acc_red;
      shadow_grn[acc_row] <= acc_grn;
    end
  end

  // Publish the shadow frame on the edge leaving COMMIT, unless capture was dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RedFrame    <= '0;
      GrnFrame    <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (state == ST_COMMIT) && capture_en;
      if ((state == ST_COMMIT) && capture_en) begin
        RedFrame <= shadow_red;
        GrnFrame <= shadow_grn;
      end
    end
  end

  // Saturating count of frames that reached row 15 incomplete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped_frames <= '0;
    end else if (drop_req && (dropped_frames != 8'hFF)) begin
      dropped_frames <= dropped_frames + 8'd1;
    end
  end

endmodule

// File: tb/tb_led_scan_capture.sv
// Bench for led_scan_capture: table-driven sweeps, directed corner sequences
// and randomized scan traffic compared cycle by cycle against a frame model.
module tb_led_scan_capture;

  localparam int S    = 4;
  localparam int HOLD = S + 2;
`ifdef LED_CAPTURE_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              capture_en = 1'b0;
  logic [35:0]       scan_in = '0;
  logic [15:0][15:0] RedFrame;
  logic [15:0][15:0] GrnFrame;
  logic              frame_valid;
  logic [7:0]        dropped_frames;
  logic              seq_err;

  int errors = 0;
  int checks = 0;
  int nprint = 0;

  led_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .capture_en    (capture_en),
    .scan_in       (scan_in),
    .RedFrame      (RedFrame),
    .GrnFrame      (GrnFrame),
    .frame_valid   (frame_valid),
    .dropped_frames(dropped_frames),
    .seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [35:0]  w1, w2;          // words sampled on the last two edges
  logic [255:0] ok_hist;         // per-edge "enabled and unchanged" history
  logic [15:0]  m_sh_red[16], m_sh_grn[16], m_red[16], m_grn[16];
  logic [15:0]  m_mask;
  bit           m_valid, m_pend, m_seq, m_have, prev_valid;
  int           m_drops, m_last;

  int stepno = 0, vcount = 0, vstep = 0, r15_step = 0;

  task automatic model_reset();
    w1 = '0; w2 = '0; ok_hist = '0; m_mask = '0;
    m_valid = 0; m_pend = 0; m_seq = 0; m_have = 0; m_drops = 0; m_last = 0;
    for (int r = 0; r < 16; r++) begin
      m_sh_red[r] = '0; m_sh_grn[r] = '0; m_red[r] = '0; m_grn[r] = '0;
    end
  endtask

  // Called just before a rising edge with the inputs the DUT is about to sample.
  task automatic model_edge();
    bit ok, acc, bad;
    int row;
    logic [15:0] bitv;
    if (!reset) begin
      model_reset();
      return;
    end
    ok = capture_en && (w1 == w2);
    ok_hist = {ok_hist[254:0], ok};
    acc = !ok_hist[S-1];
    for (int i = 0; i < S - 1; i++) if (!ok_hist[i]) acc = 0;
    m_valid = 0;
    if (m_pend && capture_en) begin
      m_red = m_sh_red; m_grn = m_sh_grn; m_valid = 1;
    end
    m_pend = 0;
    if (!capture_en) begin
      m_mask = '0; m_have = 0;
    end else if (acc) begin
      row = int'(w1[3:0]);
      m_sh_red[row] = w1[19:4];
      m_sh_grn[row] = w1[35:20];
      bitv = 16'd1 << row;
      bad = SEQ_ON && m_have && (row != (m_last + 1) % 16);
      if (bad) begin
        m_seq = 1; m_mask = bitv;
      end else if (row == 15) begin
        if ((m_mask | bitv) == 16'hFFFF) m_pend = 1;
        else if (m_drops < 255) m_drops++;
        m_mask = '0;
      end else begin
        m_mask = m_mask | bitv;
      end
      m_last = row; m_have = 1;
    end
    w2 = w1; w1 = scan_in;
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(string name, logic [15:0][15:0] act, logic [15:0][15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    bit bad;
    bad = (frame_valid !== m_valid) || (dropped_frames !== 8'(m_drops)) ||
          (seq_err !== m_seq) || (frame_valid && prev_valid);
    for (int r = 0; r < 16; r++)
      if (RedFrame[r] !== m_red[r] || GrnFrame[r] !== m_grn[r]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      if (nprint < 30)
        $display("FAIL scoreboard step=%0d valid=%b exp=%b drops=%0d exp=%0d seq=%b exp=%b red0=%h exp=%h",
                 stepno, frame_valid, m_valid, dropped_frames, m_drops, seq_err, m_seq,
                 RedFrame[0], m_red[0]);
      nprint++;
    end
    if (frame_valid) begin
      vcount++; vstep = stepno;
    end
    prev_valid = frame_valid;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    stepno++;
    sb_check();
  endtask

  task automatic drive(int row, logic [15:0] red, logic [15:0] grn, int hold);
    scan_in = {grn, red, 4'(row)};
    if (row == 15) r15_step = stepno;
    repeat (hold) step();
  endtask

  task automatic run_sweep(int short_row, int short_hold, bit glitch);
    for (int r = 0; r < 16; r++) begin
      if (glitch && r == 3) drive(3, 16'hFFFF, 16'h0000, 2);
      drive(r, 16'h0001 << r, 16'h8000 >> r, (r == short_row) ? short_hold : HOLD);
    end
  endtask

  typedef struct {
    int short_row;
    int short_hold;
    bit glitch;
    int exp_valid;
    int exp_drops;
  } sweep_t;

  sweep_t vec[4];
  logic [15:0][15:0] diag_red, diag_grn, zero_frame;

  initial begin
    prev_valid = 0;
    zero_frame = '0;
    for (int r = 0; r < 16; r++) begin
      diag_red[r] = 16'h0001 << r;
      diag_grn[r] = 16'h8000 >> r;
    end
    vec[0] = '{-1, 0, 1'b0, 1, 0};
    vec[1] = '{ 7, 3, 1'b0, 0, 1};
    vec[2] = '{-1, 0, 1'b0, 1, 1};
    vec[3] = '{-1, 0, 1'b1, 1, 1};

    // Reset state
    scan_in = {16'h8000, 16'h0001, 4'd0};
    repeat (3) @(negedge clk);
    model_reset();
    check("rst_valid", 64'(frame_valid), 64'd0);
    check("rst_drops", 64'(dropped_frames), 64'd0);
    check("rst_seq", 64'(seq_err), 64'd0);
    check_frame("rst_red", RedFrame, zero_frame);
    check_frame("rst_grn", GrnFrame, zero_frame);
    reset = 1'b1;
    capture_en = 1'b1;

    // Table-driven sweeps
    for (int v = 0; v < 4; v++) begin
      vcount = 0;
      run_sweep(vec[v].short_row, vec[v].short_hold, vec[v].glitch);
      repeat (4) step();
      check($sformatf("sweep%0d_valid_count", v), 64'(vcount), 64'(vec[v].exp_valid));
      check($sformatf("sweep%0d_drops", v), 64'(dropped_frames), 64'(vec[v].exp_drops));
      if (vec[v].exp_valid == 1) begin
        check($sformatf("sweep%0d_latency", v), 64'(vstep - r15_step), 64'(S + 2));
        check_frame($sformatf("sweep%0d_red", v), RedFrame, diag_red);
        check_frame($sformatf("sweep%0d_grn", v), GrnFrame, diag_grn);
      end
    end

    // Out-of-order rows, then a full sweep
    vcount = 0;
    drive(0, 16'h0001, 16'h8000, HOLD);
    drive(1, 16'h0002, 16'h4000, HOLD);
    drive(2, 16'h0004, 16'h2000, HOLD);
    drive(5, 16'h0020, 16'h0400, HOLD);
    check("seq_after_row5", 64'(seq_err), 64'(SEQ_ON));
    run_sweep(-1, 0, 1'b0);
    repeat (4) step();
    check("seq_sticky", 64'(seq_err), 64'(SEQ_ON));
    check("seq_sweep_valid", 64'(vcount), 64'd1);
    check("seq_drops", 64'(dropped_frames), 64'd1);

    // capture_en dropped at row 10
    vcount = 0;
    for (int r = 0; r < 10; r++) drive(r, 16'h1111, 16'h2222, HOLD);
    drive(10, 16'h1111, 16'h2222, 2);
    capture_en = 1'b0;
    drive(10, 16'h1111, 16'h2222, HOLD - 2);
    for (int r = 11; r < 16; r++) drive(r, 16'h1111, 16'h2222, HOLD);
    repeat (3) step();
    check("cap_off_valid", 64'(vcount), 64'd0);
    check("cap_off_drops", 64'(dropped_frames), 64'd1);
    check_frame("cap_off_hold_red", RedFrame, diag_red);
    capture_en = 1'b1;
    run_sweep(-1, 0, 1'b0);
    repeat (4) step();
    check("cap_resume_valid", 64'(vcount), 64'd1);

    // Randomized traffic against the model
    begin
      int row;
      row = 0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 99) < 4) capture_en = 1'b0;
        else if ($urandom_range(0, 99) < 30) capture_en = 1'b1;
        if ($urandom_range(0, 99) < 75) row = (row + 1) % 16;
        else row = int'($urandom_range(0, 15));
        drive(row, 16'($urandom), 16'($urandom), int'($urandom_range(1, 8)));
      end
    end
    capture_en = 1'b0;
    repeat (3) step();

    // Reset asserted during COMMIT
    capture_en = 1'b1;
    run_sweep(-1, 0, 1'b0);
    check("pre_reset_drops_sane", 64'(dropped_frames), 64'(m_drops));
    vcount = 0;
    for (int r = 0; r < 15; r++) drive(r, 16'hA5A5, 16'h5A5A, HOLD);
    drive(15, 16'hA5A5, 16'h5A5A, S + 1);
    check("commit_not_yet_valid", 64'(frame_valid), 64'd0);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_commit_valid", 64'(frame_valid), 64'd0);
    check("mid_commit_drops", 64'(dropped_frames), 64'd0);
    check("mid_commit_seq", 64'(seq_err), 64'd0);
    check_frame("mid_commit_red", RedFrame, zero_frame);
    check_frame("mid_commit_grn", GrnFrame, zero_frame);
    step();
    check("mid_commit_no_strobe", 64'(vcount), 64'd0);
    check_frame("mid_commit_red_after", RedFrame, zero_frame);
    capture_en = 1'b0;
    reset = 1'b1;
    step();

    // Incomplete frames: count then saturate
    capture_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(14, 16'h0F0F, 16'hF0F0, S + 1);
      drive(15, 16'h0F0F, 16'hF0F0, S + 1);
    end
    check("drops_20", 64'(dropped_frames), 64'd20);
    for (int i = 0; i < 280; i++) begin
      drive(14, 16'h0F0F, 16'hF0F0, S + 1);
      drive(15, 16'h0F0F, 16'hF0F0, S + 1);
    end
    check("drops_saturate", 64'(dropped_frames), 64'd255);
    check_frame("drops_no_frame", RedFrame, zero_frame);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
